pulsegen: RTL and testbench

//  Programmable pulse-train generator: the output-side counterpart of dfilter.

---
 rtl/pulsegen_if.sv | 37 +++
 rtl/pulsegen.sv | 146 ++++++++++++++
 tb/tb_pulsegen.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pulsegen_if.sv
// Register-block side bundle for pulsegen: train request/abort, latched
// configuration and the generated waveform with its strobes (PULSEGEN_STATUS_EN adds pulse_cnt).
interface pulsegen_if #(
  parameter int BW = 8,
  parameter int CW = 8
);
  logic          start;
  logic          stop;
  logic          pol;
  logic [BW-1:0] act_width;
  logic [BW-1:0] inact_width;
  logic [CW-1:0] pulse_num;
  logic          data_out;
  logic          busy;
  logic          act_edge;
  logic          inact_edge;
  logic          done;
`ifdef PULSEGEN_STATUS_EN
  logic [CW-1:0] pulse_cnt;
`endif

  modport master (
`ifdef PULSEGEN_STATUS_EN
    input  pulse_cnt,
`endif
    output start, stop, pol, act_width, inact_width, pulse_num,
    input  data_out, busy, act_edge, inact_edge, done
  );

  modport slave (
`ifdef PULSEGEN_STATUS_EN
    output pulse_cnt,
`endif
    input  start, stop, pol, act_width, inact_width, pulse_num,
    output data_out, busy, act_edge, inact_edge, done
  );
endinterface

// File: rtl/pulsegen.sv
// Programmable pulse-train generator timed by refclk ticks.
// Optional PULSEGEN_STATUS_EN exposes the completed-pulse count as pulse_cnt.
module pulsegen #(
  parameter logic INIVAL = 1'b0,
  parameter int   BW     = 8,
  parameter int   CW     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         refclk,
  pulsegen_if.slave    pg
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARM      = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_INACTIVE = 2'd3
  } state_t;

  state_t        state_r;
  logic [BW-1:0] wcnt_r;
  logic [CW-1:0] pcnt_r;
  logic          pol_l_r;
  logic [BW-1:0] act_w_l_r;
  logic [BW-1:0] inact_w_l_r;
  logic [CW-1:0] pnum_l_r;
  logic          data_out_r;
  logic          busy_r;
  logic          act_edge_r;
  logic          inact_edge_r;
  logic          done_r;

  // Train sequencer: every output is a register written alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      wcnt_r       <= '0;
      pcnt_r       <= '0;
      pol_l_r      <= 1'b0;
      act_w_l_r    <= '0;
      inact_w_l_r  <= '0;
      pnum_l_r     <= '0;
      data_out_r   <= INIVAL;
      busy_r       <= 1'b0;
      act_edge_r   <= 1'b0;
      inact_edge_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      act_edge_r   <= 1'b0;
      inact_edge_r <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          data_out_r <= ~pg.pol;
          if (pg.start && !pg.stop) begin
            pol_l_r     <= pg.pol;
            act_w_l_r   <= pg.act_width;
            inact_w_l_r <= pg.inact_width;
            pnum_l_r    <= pg.pulse_num;
            wcnt_r      <= '0;
            pcnt_r      <= '0;
            busy_r      <= 1'b1;
            state_r     <= ST_ARM;
          end else begin
            busy_r      <= 1'b0;
          end
        end
        ST_ARM: begin
          if (pg.stop) begin
            data_out_r <= ~pol_l_r;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (refclk) begin
            data_out_r <= pol_l_r;
            act_edge_r <= 1'b1;
            wcnt_r     <= '0;
            state_r    <= ST_ACTIVE;
          end else begin
            state_r    <= ST_ARM;
          end
        end
        ST_ACTIVE: begin
          if (pg.stop) begin
            data_out_r   <= ~pol_l_r;
            inact_edge_r <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end else if (refclk) begin
            if (wcnt_r == act_w_l_r) begin
              data_out_r   <= ~pol_l_r;
              inact_edge_r <= 1'b1;
              wcnt_r       <= '0;
              pcnt_r       <= pcnt_r + 1'b1;
              state_r      <= ST_INACTIVE;
            end else begin
              wcnt_r       <= wcnt_r + 1'b1;
            end
          end else begin
            state_r <= ST_ACTIVE;
          end
        end
        ST_INACTIVE: begin
          if (pg.stop) begin
            data_out_r <= ~pol_l_r;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (refclk) begin
            if (wcnt_r == inact_w_l_r) begin
              // A zero pulse count never terminates; pcnt just wraps.
              if ((pnum_l_r != '0) && (pcnt_r == pnum_l_r)) begin
                done_r     <= 1'b1;
                busy_r     <= 1'b0;
                state_r    <= ST_IDLE;
              end else begin
                data_out_r <= pol_l_r;
                act_edge_r <= 1'b1;
                wcnt_r     <= '0;
                state_r    <= ST_ACTIVE;
              end
            end else begin
              wcnt_r <= wcnt_r + 1'b1;
            end
          end else begin
            state_r <= ST_INACTIVE;
          end
        end
        default: begin
          data_out_r <= INIVAL;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign pg.data_out   = data_out_r;
  assign pg.busy       = busy_r;
  assign pg.act_edge   = act_edge_r;
  assign pg.inact_edge = inact_edge_r;
  assign pg.done       = done_r;
`ifdef PULSEGEN_STATUS_EN
  assign pg.pulse_cnt  = pcnt_r;
`endif

endmodule

// File: tb/tb_pulsegen.sv
// Directed bench for pulsegen with a strobe scoreboard; refclk ticks every 3 clk.
module tb_pulsegen;
  localparam int BW = 8;
  localparam int CW = 8;

  typedef struct {
    int         cyc;
    logic [2:0] kind;   // {done, inact_edge, act_edge}
    logic       dout;
  } ev_t;

  logic clk;
  logic rst;
  logic refclk;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  ev_t  sb[$];

  pulsegen_if #(.BW(BW), .CW(CW)) intf ();

  pulsegen #(.INIVAL(1'b0), .BW(BW), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .refclk (refclk),
    .pg     (intf.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter and refclk prescaler: a tick is sampled on every posedge p with p%3==0.
  initial begin
    cyc    = 0;
    refclk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc    = cyc + 1;
      refclk = ((cyc % 3) == 2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [2:0] k, input logic d);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.dout = d;
    sb.push_back(e);
  endtask

  // Strobe monitor: every strobe must match the head of the scoreboard.
  initial begin
    ev_t        e;
    logic [2:0] k;
    forever begin
      @(negedge clk);
      k = {intf.done, intf.inact_edge, intf.act_edge};
      if (k != 3'b000) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_strobe: observed kind %b at cyc %0d expected none", k, cyc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("strobe_cyc", cyc, e.cyc);
          chk("strobe_kind", {29'd0, k}, {29'd0, e.kind});
          chk("strobe_dout", {31'd0, intf.data_out}, {31'd0, e.dout});
        end
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst              = 1'b1;
    intf.start       = 1'b0;
    intf.stop        = 1'b0;
    intf.pol         = 1'b1;
    intf.act_width   = 8'd0;
    intf.inact_width = 8'd0;
    intf.pulse_num   = 8'd0;

    // Reset state
    goto(2);
    chk("rst_data_out", {31'd0, intf.data_out}, 32'd0);
    chk("rst_busy", {31'd0, intf.busy}, 32'd0);
    chk("rst_strobes", {29'd0, intf.done, intf.inact_edge, intf.act_edge}, 32'd0);
    rst = 1'b0;

    // Two 27-clk high pulses with 15 clk low between them
    goto(4);
    intf.act_width   = 8'd8;
    intf.inact_width = 8'd4;
    intf.pulse_num   = 8'd2;
    intf.start       = 1'b1;
    push(6,  3'b001, 1'b1);
    push(33, 3'b010, 1'b0);
    push(48, 3'b001, 1'b1);
    push(75, 3'b010, 1'b0);
    push(90, 3'b100, 1'b0);
    goto(5);
    intf.start = 1'b0;
    chk("t2_busy_arm", {31'd0, intf.busy}, 32'd1);
    chk("t2_dout_arm", {31'd0, intf.data_out}, 32'd0);
    // Start and config changes while busy must be ignored
    goto(20);
    chk("t2_dout_high", {31'd0, intf.data_out}, 32'd1);
    intf.pol       = 1'b0;
    intf.act_width = 8'd0;
    intf.pulse_num = 8'd0;
    intf.start     = 1'b1;
    goto(21);
    intf.start = 1'b0;
    goto(22);
    intf.pol       = 1'b1;
    intf.act_width = 8'd8;
    intf.pulse_num = 8'd2;
    goto(40);
    chk("t2_dout_low", {31'd0, intf.data_out}, 32'd0);
    chk("t2_busy_mid", {31'd0, intf.busy}, 32'd1);
    goto(89);
    chk("t2_busy_pre_done", {31'd0, intf.busy}, 32'd1);
    goto(90);
    chk("t2_busy_done", {31'd0, intf.busy}, 32'd0);
    goto(91);
    chk("t2_dout_idle", {31'd0, intf.data_out}, 32'd0);

    // start+stop together in IDLE: stop wins
    goto(94);
    intf.start = 1'b1;
    intf.stop  = 1'b1;
    goto(95);
    intf.start = 1'b0;
    intf.stop  = 1'b0;
    chk("t4_busy", {31'd0, intf.busy}, 32'd0);
    goto(97);
    chk("t4_busy_later", {31'd0, intf.busy}, 32'd0);

    // Low-active continuous square wave, stopped while low
    goto(99);
    intf.pol         = 1'b0;
    intf.pulse_num   = 8'd0;
    intf.act_width   = 8'd0;
    intf.inact_width = 8'd0;
    intf.start       = 1'b1;
    push(102, 3'b001, 1'b0);
    push(105, 3'b010, 1'b1);
    push(108, 3'b001, 1'b0);
    push(111, 3'b010, 1'b1);
    push(114, 3'b001, 1'b0);
    push(116, 3'b010, 1'b1);
    goto(100);
    intf.start = 1'b0;
    goto(103);
    chk("t3_dout_low", {31'd0, intf.data_out}, 32'd0);
    goto(106);
    chk("t3_dout_high", {31'd0, intf.data_out}, 32'd1);
    goto(115);
    intf.stop = 1'b1;
    goto(116);
    intf.stop = 1'b0;
    chk("t3_stop_dout", {31'd0, intf.data_out}, 32'd1);
    chk("t3_stop_busy", {31'd0, intf.busy}, 32'd0);

    // Reset in the middle of an active phase
    goto(120);
    intf.pol         = 1'b1;
    intf.act_width   = 8'd8;
    intf.inact_width = 8'd4;
    intf.pulse_num   = 8'd1;
    intf.start       = 1'b1;
    push(123, 3'b001, 1'b1);
    goto(121);
    intf.start = 1'b0;
    goto(130);
    chk("t5_dout_active", {31'd0, intf.data_out}, 32'd1);
    rst = 1'b1;
    goto(131);
    rst = 1'b0;
    chk("t5_rst_dout", {31'd0, intf.data_out}, 32'd0);
    chk("t5_rst_busy", {31'd0, intf.busy}, 32'd0);

    // Fresh single-pulse train after reset
    goto(134);
    intf.act_width   = 8'd1;
    intf.inact_width = 8'd0;
    intf.pulse_num   = 8'd1;
    intf.start       = 1'b1;
    push(138, 3'b001, 1'b1);
    push(144, 3'b010, 1'b0);
    push(147, 3'b100, 1'b0);
    goto(135);
    intf.start = 1'b0;
    chk("t5_busy_restart", {31'd0, intf.busy}, 32'd1);
`ifdef PULSEGEN_STATUS_EN
    goto(145);
    chk("t6_cnt_single", {24'd0, intf.pulse_cnt}, 32'd1);
`endif
    goto(147);
    chk("t5_busy_done", {31'd0, intf.busy}, 32'd0);

    // Three single-tick pulses
    goto(150);
    intf.act_width   = 8'd0;
    intf.inact_width = 8'd0;
    intf.pulse_num   = 8'd3;
    intf.start       = 1'b1;
    push(153, 3'b001, 1'b1);
    push(156, 3'b010, 1'b0);
    push(159, 3'b001, 1'b1);
    push(162, 3'b010, 1'b0);
    push(165, 3'b001, 1'b1);
    push(168, 3'b010, 1'b0);
    push(171, 3'b100, 1'b0);
    goto(151);
    intf.start = 1'b0;
`ifdef PULSEGEN_STATUS_EN
    chk("t6_cnt_clear", {24'd0, intf.pulse_cnt}, 32'd0);
    goto(157);
    chk("t6_cnt_1", {24'd0, intf.pulse_cnt}, 32'd1);
    goto(163);
    chk("t6_cnt_2", {24'd0, intf.pulse_cnt}, 32'd2);
    goto(169);
    chk("t6_cnt_3", {24'd0, intf.pulse_cnt}, 32'd3);
    goto(175);
    chk("t6_cnt_hold", {24'd0, intf.pulse_cnt}, 32'd3);
`endif
    goto(171);
    chk("t6_busy_done", {31'd0, intf.busy}, 32'd0);

    goto(180);
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
